// File: rtl/sq_dist_accum.sv
// sq_dist_accum: accumulates squared sign-magnitude differences into a saturated distance
module sq_dist_accum #(
  parameter int XLEN_PIXEL = 8,
  parameter int FRAC_BITS  = 8,
  parameter int N_FEAT     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*XLEN_PIXEL-1:0] in_diff,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*XLEN_PIXEL-1:0] out_dist,
  output logic                    out_sat
);
  localparam int W   = 2*XLEN_PIXEL;
  localparam int M   = W-1;
  localparam int SQW = 2*M-FRAC_BITS;
  localparam int AW  = SQW+$clog2(N_FEAT);
  localparam int CW  = $clog2(N_FEAT)+1;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
  state_t state;
  logic [M-1:0] mag;
  logic [2*M-1:0] prod;
  logic [SQW-1:0] sq, sq_r;
  logic sq_v, accept, acc_sat;
  logic [AW-1:0] acc, acc_nx;
  logic [CW-1:0] cnt;
  assign mag      = in_diff[M-1:0];
  assign prod     = mag * mag;
  assign sq       = SQW'(prod >> FRAC_BITS);
  assign acc_nx   = sq_v ? acc + AW'(sq_r) : acc;
  assign acc_sat  = |acc_nx[AW-1:M];
  assign in_ready = (state == IDLE) || (state == ACCUM);
  assign accept   = in_valid && in_ready;
  // square pipeline, accumulator and handshake FSM; DRAIN folds in the last square
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      sq_r      <= '0;
      sq_v      <= 1'b0;
      out_valid <= 1'b0;
      out_dist  <= '0;
      out_sat   <= 1'b0;
    end else begin
      sq_v <= accept;
      acc  <= acc_nx;
      if (accept) begin
        sq_r <= sq;
        cnt  <= cnt + 1'b1;
      end
      case (state)
        IDLE:  if (accept) state <= ACCUM;
        ACCUM: if (accept && cnt == CW'(N_FEAT-1)) state <= DRAIN;
        DRAIN: begin
          out_dist  <= {1'b0, acc_sat ? {M{1'b1}} : acc_nx[M-1:0]};
          out_sat   <= acc_sat;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        default: if (out_ready) begin
          out_valid <= 1'b0;
          acc       <= '0;
          cnt       <= '0;
          sq_v      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sq_dist_accum.sv
// tb_sq_dist_accum: directed self-checking bench for sq_dist_accum
module tb_sq_dist_accum;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_sat;
  logic [15:0] in_diff = '0, out_dist;
  logic [15:0] v [16];
  int checks = 0, errors = 0;

  sq_dist_accum #(.XLEN_PIXEL(8), .FRAC_BITS(8), .N_FEAT(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_diff(in_diff),
    .out_valid(out_valid), .out_ready(out_ready), .out_dist(out_dist), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic [15:0] d);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_diff  = d;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
  endtask

  task automatic run_vec(input string tag, input logic [15:0] d [16], input bit gaps,
                         input logic [15:0] exp_dist, input logic exp_sat);
    for (int i = 0; i < 16; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      beat(d[i]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_lat_early"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_rdy_drain"}, {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_dist"}, {16'b0, out_dist}, {16'b0, exp_dist});
    chk({tag, "_sat"}, {31'b0, out_sat}, {31'b0, exp_sat});
  endtask

  task automatic take_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_valid_clr"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_rdy_idle"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [15:0] held;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_dist", {16'b0, out_dist}, 32'd0);
    chk("rst_sat", {31'b0, out_sat}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < 16; i++) v[i] = 16'h0100;
    run_vec("t1", v, 1'b0, 16'h1000, 1'b0);
    take_out("t1");

    for (int i = 0; i < 16; i++) v[i] = (i % 2 == 0) ? 16'h8200 : 16'h0200;
    run_vec("t2", v, 1'b0, 16'h4000, 1'b0);
    take_out("t2");

    for (int i = 0; i < 16; i++) v[i] = 16'h0C00;
    run_vec("t3", v, 1'b0, 16'h7FFF, 1'b1);
    take_out("t3");

    for (int i = 0; i < 16; i++) v[i] = 16'h0100;
    run_vec("t4a", v, 1'b0, 16'h1000, 1'b0);
    held = out_dist;
    in_valid = 1'b1;
    in_diff  = 16'h0700;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_hold_dist", {16'b0, out_dist}, {16'b0, held});
      chk("t4_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("t4_hold_rdy", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    take_out("t4a");
    run_vec("t4b", v, 1'b0, 16'h1000, 1'b0);
    take_out("t4b");

    for (int i = 0; i < 7; i++) beat(16'h0300);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("t5_rst_dist", {16'b0, out_dist}, 32'd0);
    chk("t5_rst_sat", {31'b0, out_sat}, 32'd0);
    chk("t5_rst_idle", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("t5", v, 1'b0, 16'h1000, 1'b0);
    take_out("t5");

    for (int i = 0; i < 16; i++) v[i] = 16'h0000;
    v[0] = 16'h8000;
    v[1] = 16'h0001;
    v[2] = 16'h0180;
    run_vec("t6", v, 1'b1, 16'h0240, 1'b0);
    take_out("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
